// File: rtl/uib_arbiter_if.sv
// uib_arbiter_if: request/grant bundle between the uib masters and the arbiter.
// The master modport is the requester side (it also drives bus_ready, as the
// bus stand-in). The slave modport is the arbiter side.
interface uib_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int ID_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic                 bus_ready;
    logic [N_MASTERS-1:0] grant;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic [N_MASTERS-1:0] master_ready;
    logic                 timeout;

    modport master (
        output req,
        output bus_ready,
        input  grant,
        input  grant_id,
        input  busy,
        input  master_ready,
        input  timeout
    );

    modport slave (
        input  req,
        input  bus_ready,
        output grant,
        output grant_id,
        output busy,
        output master_ready,
        output timeout
    );
endinterface

// File: rtl/uib_arbiter.sv
// uib_arbiter: round-robin arbiter for the shared uib transaction path.
// One master is granted at a time. The grant holds until bus_ready or until
// the master abandons its request. A one-cycle TURN gap follows every grant.
// Optional feature: define UIB_ARB_TIMEOUT_EN to abort grants that stay open
// TIMEOUT cycles without bus_ready.
module uib_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    uib_arbiter_if.slave     bus
);
    localparam int ID_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [N_MASTERS-1:0] grant_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [ID_W-1:0]      last;
    logic                 winner_found;
    logic [ID_W-1:0]      winner_id;
    logic                 expire;

    // Round-robin search: first requester at or after last+1, wrapping
    always_comb begin
        int idx;
        idx          = 0;
        winner_found = 1'b0;
        winner_id    = '0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            idx = (int'(last) + off) % N_MASTERS;
            if (!winner_found && bus.req[idx[ID_W-1:0]]) begin
                winner_found = 1'b1;
                winner_id    = idx[ID_W-1:0];
            end
        end
    end

`ifdef UIB_ARB_TIMEOUT_EN
    logic [15:0] wait_count;

    // Count BUSY cycles spent waiting for bus_ready; restart on every new grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_count <= '0;
        end else if (state == IDLE && winner_found) begin
            wait_count <= '0;
        end else if (state == BUSY && !bus.bus_ready) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    // Abort fires in the cycle the count reaches TIMEOUT; bus_ready that same cycle wins
    always_comb begin
        expire = (state == BUSY) && !bus.bus_ready &&
                 ((wait_count + 16'd1) == 16'(TIMEOUT));
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);

    // Without the timeout feature a grant never expires
    always_comb begin
        expire = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant, then wait for completion/abandon/abort, then a gap cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (bus.bus_ready || !bus.req[grant_id_q] || expire) begin
                    next_state = TURN;
                end
            end
            TURN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant registers: load the winner on grant, freeze while BUSY, clear when leaving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            last       <= ID_W'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (winner_found) begin
                        grant_q    <= {{(N_MASTERS-1){1'b0}}, 1'b1} << winner_id;
                        grant_id_q <= winner_id;
                        last       <= winner_id;
                    end
                end
                BUSY: begin
                    if (next_state != BUSY) begin
                        grant_q    <= '0;
                        grant_id_q <= '0;
                    end
                end
                default: begin
                    grant_q    <= '0;
                    grant_id_q <= '0;
                end
            endcase
        end
    end

    // Outputs: busy from state, ready gated by the held grant, timeout pulse
    always_comb begin
        bus.grant        = grant_q;
        bus.grant_id     = grant_id_q;
        bus.busy         = (state == BUSY);
        bus.master_ready = grant_q & {N_MASTERS{bus.bus_ready}};
        bus.timeout      = expire;
    end
endmodule

// File: tb/tb_uib_arbiter.sv
// tb_uib_arbiter: randomized and directed scoreboard bench for uib_arbiter.
// A transaction-level model predicts each cycle's outputs; a negedge monitor
// pops the prediction and compares it with the DUT.
module tb_uib_arbiter;
    localparam int N    = 4;
    localparam int TMO  = 4;
    localparam int ID_W = $clog2(N);
`ifdef UIB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]    grant;
        logic [ID_W-1:0] id;
        logic            busy;
        logic [N-1:0]    mr;
        logic            tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t exp_q[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    // Model: who owns the bus (-1 = nobody), whether we are in the gap cycle,
    // the last winner and how long the owner has waited for bus_ready.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_last  = N - 1;
    int m_age   = 0;

    always #5 clk = ~clk;

    uib_arbiter_if #(.N_MASTERS(N)) bus ();

    uib_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the model says the DUT shows this cycle
    task automatic apply_stimulus(input logic r, input logic [N-1:0] rq, input logic br);
        exp_t e;
        bit   abort;
        @(posedge clk);
        #1;
        rst           = r;
        bus.req       = rq;
        bus.bus_ready = br;
        e = '{grant: '0, id: '0, busy: 1'b0, mr: '0, tmo: 1'b0};
        if (r) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_last  = N - 1;
            m_age   = 0;
        end else if (m_owner >= 0) begin
            abort   = TO_EN && !br && (m_age + 1 == TMO);
            e.grant = N'(1) << m_owner;
            e.id    = ID_W'(m_owner);
            e.busy  = 1'b1;
            e.mr    = br ? e.grant : '0;
            e.tmo   = abort;
            if (br || !rq[m_owner] || abort) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && rq[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_age  = 0;
            end
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest prediction, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("grant", 32'(bus.grant), 32'(e.grant));
            check_output("grant_id", 32'(bus.grant_id), 32'(e.id));
            check_output("busy", 32'(bus.busy), 32'(e.busy));
            check_output("master_ready", 32'(bus.master_ready), 32'(e.mr));
            check_output("timeout", 32'(bus.timeout), 32'(e.tmo));
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] drop;
        bus.req       = '0;
        bus.bus_ready = 1'b0;
        #1 rst = 1'b1;

        // Reset state, then reset in the middle of a master-2 grant
        repeat (2) apply_stimulus(1'b1, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b1, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0101, 1'b0);
        apply_stimulus(1'b0, 4'b0101, 1'b0);
        apply_stimulus(1'b0, 4'b0101, 1'b1);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Single request with bus_ready three cycles later
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Rotation with every master requesting, ready while a grant is held
        for (int c = 0; c < 16; c++) begin
            apply_stimulus(1'b0, 4'b1111, (m_owner >= 0));
        end
        apply_stimulus(1'b1, 4'b0000, 1'b0);

        // Abandon by master 1, ready pulsed during the gap cycle
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0010, 1'b0);
        apply_stimulus(1'b0, 4'b1010, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b1);
        apply_stimulus(1'b0, 4'b1000, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Master 3 stuck without bus_ready while master 0 waits
        apply_stimulus(1'b0, 4'b1000, 1'b0);
        for (int c = 0; c < 12; c++) begin
            apply_stimulus(1'b0, 4'b1001, 1'b0);
        end
        apply_stimulus(1'b1, 4'b0000, 1'b0);

        // Randomized masters: hold req until ready, drop it next cycle, sometimes abandon
        rq   = '0;
        drop = '0;
        for (int c = 0; c < 400; c++) begin
            rq = rq & ~drop;
            if (m_owner >= 0 && $urandom_range(0, 15) == 0) begin
                rq[m_owner] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && !drop[i] && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                end
            end
            apply_stimulus(1'b0, rq, ($urandom_range(0, 3) == 0));
            drop = last_exp.mr;
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uib_arbiter.md
# uib_arbiter

Round-robin bus arbiter that shares the single uib transaction path among several masters (CPU, future DMA/debug masters). It samples per-master request lines, grants exactly one master at a time, holds the grant until the bus signals completion, and then rotates priority. It sits between the master request wires and the uib master-select logic: its one-hot grant steers the bus mux, and its gated ready returns completion only to the granted master.

## Interface

Parameters:
- N_MASTERS, 4: number of requesting masters; legal range 2..16.
- TIMEOUT, 255: cycles a grant may stay open without ready before it is aborted. Used only when UIB_ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_MASTERS  per-master request, level. A master holds its bit high until it sees its ready bit, then drops it the following cycle.
- bus_ready  in  1  completion from the bus for the currently granted transaction.
- grant  out  N_MASTERS  one-hot grant, registered; all zero when no master is granted.
- grant_id  out  $clog2(N_MASTERS)  index of the granted master; 0 when idle.
- busy  out  1  high while any grant is held.
- master_ready  out  N_MASTERS  bus_ready AND grant, combinational.
- timeout  out  1  one-cycle pulse when a grant is aborted; constant 0 when the feature is compiled out.

## Operation

- State machine with three states: IDLE, BUSY, TURN.
- IDLE: if any req bit is high, pick a winner by round-robin, load grant/grant_id, set busy, go to BUSY. Otherwise stay in IDLE with grant=0.
- Round-robin: the search starts at last+1 (mod N_MASTERS) and increments. `last` is the index of the most recent winner. `last` resets to N_MASTERS-1, so master 0 has top priority after reset. `last` updates when the grant is issued.
- BUSY: grant is frozen; req changes on other masters are ignored.
  - bus_ready=1: the transaction completes; go to TURN.
  - Granted master drops req while bus_ready=0: the transaction is abandoned; go to TURN.
- TURN: one cycle with grant=0 and busy=0. This absorbs the master's req deassert. Always go to IDLE next.
- bus_ready while in IDLE or TURN is ignored; master_ready stays 0 because grant=0.
- Reset at any time, including mid-BUSY: grant=0, grant_id=0, busy=0, timeout=0, state IDLE, last=N_MASTERS-1, timeout counter=0. No grant survives reset.

## Timing

- Reset values: grant=0, grant_id=0, busy=0, master_ready=0, timeout=0.
- Grant latency: req high in an IDLE cycle t gives grant in cycle t+1.
- Completion: bus_ready in cycle t means grant=0 in t+1 (TURN). The earliest next grant is t+3: IDLE sampled at t+2, grant at t+3.
- Back-to-back throughput with two always-requesting masters: one grant every 3 cycles plus the bus latency. Grants alternate strictly between the two.
- master_ready is combinational with the same-cycle bus_ready. It is never asserted to a non-granted master.

## Configuration

- UIB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on grant and increments each BUSY cycle with bus_ready=0.
  - When the counter reaches TIMEOUT, that cycle: timeout pulses for one cycle, and the state goes to TURN (grant drops next cycle).
  - `last` keeps the aborted master's index, so priority rotates past it.
  - bus_ready in the same cycle as expiry wins: it counts as normal completion and timeout is not pulsed.
- UIB_ARB_TIMEOUT_EN undefined: no counter; timeout is tied to 0; BUSY lasts until bus_ready or req drop, without limit.

## Test plan

- Reset mid-BUSY: grant master 2, assert rst in the BUSY state -> grant=0, busy=0 immediately. After release, req=4'b0101 -> grant=4'b0001 (master 0 first).
- Single request: req=4'b0100 at cycle t, bus_ready at t+3 -> grant=4'b0100 from t+1 to t+3, master_ready=4'b0100 at t+3 only, grant=0 at t+4.
- Rotation: req=4'b1111 held and bus_ready pulsed one cycle after each grant -> grant_id sequence 0,1,2,3,0 with a TURN cycle of grant=0 between grants.
- Abandon: master 1 is granted and drops req before any bus_ready -> next cycle grant=0 (TURN), then the next requester is granted. A bus_ready pulsed during TURN produces master_ready=0.
- Timeout (macro on, TIMEOUT=4): master 3 is granted and bus_ready is never asserted -> timeout pulses at the 4th BUSY cycle, grant=0 the next cycle, and pending master 0 is granted afterwards. With the macro off, the same stimulus keeps master 3 granted indefinitely and timeout stays 0.
